// File: rtl/if_id_buffer.sv
// IF/ID pipeline register with instruction assembly.
// Registers fetched words and assembles one- or two-word instructions:
// a first word with bit [0] set is followed by an immediate word. The
// assembled instruction is presented to decode one clock after its last
// word is sampled. Flush discards everything in flight; stall freezes
// all state and drops the incoming word.
module if_id_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [INSTR_WIDTH-1:0] out_imm,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   out_has_imm,
  output logic                   out_valid,
  output logic [15:0]            out_count
);

  typedef enum logic {
    S_FIRST = 1'b0,  // expecting an opcode word
    S_IMM   = 1'b1   // opcode held, expecting its immediate word
  } state_t;

  state_t                 r_state;
  logic [INSTR_WIDTH-1:0] r_hold_instr;
  logic [PC_WIDTH-1:0]    r_hold_pc;
  logic [INSTR_WIDTH-1:0] r_out_instr;
  logic [INSTR_WIDTH-1:0] r_out_imm;
  logic [PC_WIDTH-1:0]    r_out_pc;
  logic                   r_out_has_imm;
  logic                   r_out_valid;
  logic [15:0]            r_out_count;

  // Delivered-instruction counter saturates instead of wrapping.
  logic [15:0] w_count_next;
  assign w_count_next = (r_out_count == 16'hFFFF) ? r_out_count : r_out_count + 16'd1;

  // Assembly FSM with registered outputs; flush outranks stall, stall outranks fetch.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; blocking = would let later statements see updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every flop in this block is a plain register (no memory array),
      // so all of it is cleared asynchronously, including the hold registers.
      r_state       <= S_FIRST;
      r_hold_instr  <= '0;
      r_hold_pc     <= '0;
      r_out_instr   <= '0;
      r_out_imm     <= '0;
      r_out_pc      <= '0;
      r_out_has_imm <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_count   <= '0;
    end else if (flush) begin
      // Discard the in-flight word and anything held; out_pc is kept for debug.
      r_state       <= S_FIRST;
      r_hold_instr  <= '0;
      r_hold_pc     <= '0;
      r_out_instr   <= '0;
      r_out_imm     <= '0;
      r_out_has_imm <= 1'b0;
      r_out_valid   <= 1'b0;
    end else if (stall) begin
      // Decode is busy: everything holds and the incoming word is dropped.
      r_state <= r_state;
    end else if (!in_valid) begin
      // Bubble: nothing new to present, but a pending opcode keeps waiting.
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_FIRST: begin
          if (!instr_in[0]) begin
            r_out_instr   <= instr_in;
            r_out_pc      <= pc_in;
            r_out_imm     <= '0;
            r_out_has_imm <= 1'b0;
            r_out_valid   <= 1'b1;
            r_out_count   <= w_count_next;
          end else begin
            r_hold_instr <= instr_in;
            r_hold_pc    <= pc_in;
            r_out_valid  <= 1'b0;
            r_state      <= S_IMM;
          end
        end
        S_IMM: begin
          // The word arriving here is data; its bit [0] is not decoded.
          r_out_instr   <= r_hold_instr;
          r_out_pc      <= r_hold_pc;
          r_out_imm     <= instr_in;
          r_out_has_imm <= 1'b1;
          r_out_valid   <= 1'b1;
          r_out_count   <= w_count_next;
          r_state       <= S_FIRST;
        end
        default: r_state <= S_FIRST;
      endcase
    end
  end

  assign out_instr   = r_out_instr;
  assign out_imm     = r_out_imm;
  assign out_pc      = r_out_pc;
  assign out_has_imm = r_out_has_imm;
  assign out_valid   = r_out_valid;
  assign out_count   = r_out_count;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based model.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic [31:0] pc_in;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic [31:0] out_pc;
  logic        out_has_imm;
  logic        out_valid;
  logic [15:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  if_id_buffer #(.PC_WIDTH(32), .INSTR_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .pc_in      (pc_in),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .out_instr  (out_instr),
    .out_imm    (out_imm),
    .out_pc     (out_pc),
    .out_has_imm(out_has_imm),
    .out_valid  (out_valid),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic f,
                       input logic [15:0] w, input logic [31:0] pc);
    in_valid = v;
    stall    = s;
    flush    = f;
    instr_in = w;
    pc_in    = pc;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- reference model ----------------
  // Accepted words are queued; an instruction is complete when the queue
  // front is an even opcode (one word) or an odd opcode plus one more word.
  typedef struct {
    logic [15:0] w;
    logic [31:0] pc;
  } word_t;

  word_t       q[$];
  logic        m_valid, m_has, m_flushed;
  logic [15:0] m_instr, m_imm, m_count;
  logic [31:0] m_pc;

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_has = 0; m_flushed = 1;
    m_instr = 0; m_imm = 0; m_count = 0; m_pc = 0;
  endtask

  task automatic model_deliver(input logic [15:0] i, input logic [15:0] imm,
                               input logic has, input logic [31:0] pc);
    m_valid = 1; m_instr = i; m_imm = imm; m_has = has; m_pc = pc;
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
  endtask

  task automatic model_step(input logic v, input logic s, input logic f,
                            input logic [15:0] w, input logic [31:0] pc);
    word_t nw;
    if (f) begin
      q.delete();
      m_valid = 0; m_has = 0; m_instr = 0; m_imm = 0; m_flushed = 1;
    end else if (s) begin
      // frozen
    end else if (!v) begin
      m_valid = 0;
    end else begin
      nw.w = w; nw.pc = pc;
      q.push_back(nw);
      m_flushed = 0;
      if (q[0].w[0] == 1'b0) begin
        model_deliver(q[0].w, 16'h0, 1'b0, q[0].pc);
        q.delete();
      end else if (q.size() == 2) begin
        model_deliver(q[0].w, q[1].w, 1'b1, q[0].pc);
        q.delete();
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_model(input int cyc);
    check($sformatf("rnd%0d valid", cyc), 64'(out_valid), 64'(m_valid));
    check($sformatf("rnd%0d count", cyc), 64'(out_count), 64'(m_count));
    if (m_valid || m_flushed) begin
      check($sformatf("rnd%0d instr", cyc), 64'(out_instr), 64'(m_instr));
      check($sformatf("rnd%0d imm", cyc), 64'(out_imm), 64'(m_imm));
      check($sformatf("rnd%0d has_imm", cyc), 64'(out_has_imm), 64'(m_has));
      check($sformatf("rnd%0d pc", cyc), 64'(out_pc), 64'(m_pc));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] w;
    logic [31:0] pc;
    logic        v;
    logic        e_valid;
    logic        e_has;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [31:0] e_pc;
    logic [15:0] e_count;
    logic        chk_fields;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    #2;
    // Reset state, before any clock edge.
    check("reset valid", 64'(out_valid), 64'd0);
    check("reset instr", 64'(out_instr), 64'd0);
    check("reset imm", 64'(out_imm), 64'd0);
    check("reset pc", 64'(out_pc), 64'd0);
    check("reset has_imm", 64'(out_has_imm), 64'd0);
    check("reset count", 64'(out_count), 64'd0);
    do_reset();

    //          word      pc     v  val has instr     imm       pc      cnt  chk
    vecs[0]  = '{16'h1234, 32'h20, 1, 1, 0, 16'h1234, 16'h0000, 32'h20, 16'd1, 1};
    vecs[1]  = '{16'h5678, 32'h21, 1, 1, 0, 16'h5678, 16'h0000, 32'h21, 16'd2, 1};
    vecs[2]  = '{16'h0A01, 32'h22, 1, 0, 0, 16'h0000, 16'h0000, 32'h00, 16'd2, 0};
    vecs[3]  = '{16'hBEEF, 32'h23, 1, 1, 1, 16'h0A01, 16'hBEEF, 32'h22, 16'd3, 1};
    vecs[4]  = '{16'h0000, 32'h00, 0, 0, 0, 16'h0000, 16'h0000, 32'h00, 16'd3, 0};
    vecs[5]  = '{16'h0A01, 32'h30, 1, 0, 0, 16'h0000, 16'h0000, 32'h00, 16'd3, 0};
    vecs[6]  = '{16'h0B03, 32'h31, 1, 1, 1, 16'h0A01, 16'h0B03, 32'h30, 16'd4, 1};
    vecs[7]  = '{16'h0004, 32'h32, 1, 1, 0, 16'h0004, 16'h0000, 32'h32, 16'd5, 1};
    vecs[8]  = '{16'h0C05, 32'h40, 1, 0, 0, 16'h0000, 16'h0000, 32'h00, 16'd5, 0};
    vecs[9]  = '{16'h0000, 32'h00, 0, 0, 0, 16'h0000, 16'h0000, 32'h00, 16'd5, 0};
    vecs[10] = '{16'h1111, 32'h41, 1, 1, 1, 16'h0C05, 16'h1111, 32'h40, 16'd6, 1};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, 1'b0, 1'b0, vecs[i].w, vecs[i].pc);
      step();
      check($sformatf("vec%0d valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d count", i), 64'(out_count), 64'(vecs[i].e_count));
      if (vecs[i].chk_fields) begin
        check($sformatf("vec%0d instr", i), 64'(out_instr), 64'(vecs[i].e_instr));
        check($sformatf("vec%0d imm", i), 64'(out_imm), 64'(vecs[i].e_imm));
        check($sformatf("vec%0d pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
        check($sformatf("vec%0d has_imm", i), 64'(out_has_imm), 64'(vecs[i].e_has));
      end
    end

    // ---- stall: outputs frozen, dropped words, immediate pairs later ----
    do_reset();
    drive(1, 0, 0, 16'h1234, 32'h20); step();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 16'h4444, 32'h99); step();
      check("stall1 valid", 64'(out_valid), 64'd1);
      check("stall1 instr", 64'(out_instr), 64'h1234);
      check("stall1 pc", 64'(out_pc), 64'h20);
      check("stall1 count", 64'(out_count), 64'd1);
    end
    drive(1, 0, 0, 16'h0A01, 32'h22); step();
    check("stall2 pre valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'h0007, 32'h77); step();
      check("stall2 valid", 64'(out_valid), 64'd0);
      check("stall2 count", 64'(out_count), 64'd1);
    end
    drive(1, 0, 0, 16'hBEEF, 32'h23); step();
    check("stall2 pair valid", 64'(out_valid), 64'd1);
    check("stall2 pair instr", 64'(out_instr), 64'h0A01);
    check("stall2 pair imm", 64'(out_imm), 64'hBEEF);
    check("stall2 pair pc", 64'(out_pc), 64'h22);
    check("stall2 pair has_imm", 64'(out_has_imm), 64'd1);
    check("stall2 pair count", 64'(out_count), 64'd2);

    // ---- flush beats stall and in_valid; out_pc retained ----
    do_reset();
    drive(1, 0, 0, 16'h1234, 32'h20); step();
    drive(1, 0, 0, 16'h0A01, 32'h22); step();
    drive(1, 1, 1, 16'h5555, 32'h55); step();
    check("flush valid", 64'(out_valid), 64'd0);
    check("flush instr", 64'(out_instr), 64'd0);
    check("flush imm", 64'(out_imm), 64'd0);
    check("flush has_imm", 64'(out_has_imm), 64'd0);
    check("flush pc kept", 64'(out_pc), 64'h20);
    check("flush count", 64'(out_count), 64'd1);
    drive(1, 0, 0, 16'h0002, 32'h50); step();
    check("post flush valid", 64'(out_valid), 64'd1);
    check("post flush instr", 64'(out_instr), 64'h0002);
    check("post flush has_imm", 64'(out_has_imm), 64'd0);
    check("post flush pc", 64'(out_pc), 64'h50);
    check("post flush count", 64'(out_count), 64'd2);

    // ---- asynchronous reset while in S_IMM ----
    drive(1, 0, 0, 16'h0A01, 32'h22); step();
    drive(0, 0, 0, 16'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", 64'(out_valid), 64'd0);
    check("async rst instr", 64'(out_instr), 64'd0);
    check("async rst pc", 64'(out_pc), 64'd0);
    check("async rst count", 64'(out_count), 64'd0);
    check("async rst has_imm", 64'(out_has_imm), 64'd0);
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 16'hBEEF, 32'h60); step();
    check("after rst opcode valid", 64'(out_valid), 64'd0);
    drive(1, 0, 0, 16'h0100, 32'h61); step();
    check("after rst pair valid", 64'(out_valid), 64'd1);
    check("after rst pair instr", 64'(out_instr), 64'hBEEF);
    check("after rst pair imm", 64'(out_imm), 64'h0100);
    check("after rst pair pc", 64'(out_pc), 64'h60);
    check("after rst count", 64'(out_count), 64'd1);

    // ---- randomized run against the queue model ----
    do_reset();
    model_reset();
    begin
      logic [31:0] pc_ctr = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
        logic v, s, f;
        logic [15:0] w;
        v = ($urandom_range(0, 99) < 75);
        s = ($urandom_range(0, 99) < 15);
        f = ($urandom_range(0, 99) < 5);
        w = 16'($urandom);
        drive(v, s, f, w, pc_ctr);
        step();
        model_step(v, s, f, w, pc_ctr);
        compare_model(c);
        if (v && !s && !f) pc_ctr = pc_ctr + 32'd1;
      end
    end

    // ---- counter saturation ----
    do_reset();
    drive(1, 0, 0, 16'h0002, 32'h0);
    for (int i = 0; i < 65534; i++) step();
    check("sat count FFFE", 64'(out_count), 64'hFFFE);
    step();
    step();
    check("sat count FFFF", 64'(out_count), 64'hFFFF);
    for (int i = 0; i < 3; i++) step();
    check("sat count held", 64'(out_count), 64'hFFFF);
    check("sat still valid", 64'(out_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of the program-counter value carried with each instruction.
REQ-002 Parameter INSTR_WIDTH, default 16, width of one instruction-memory word.
REQ-003 clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 instr_in  input  INSTR_WIDTH  word fetched from instruction memory this cycle.
REQ-006 pc_in  input  PC_WIDTH  address of instr_in.
REQ-007 in_valid  input  1  instr_in/pc_in carry a real fetched word this cycle.
REQ-008 stall  input  1  decode cannot accept; hold all state.
REQ-009 flush  input  1  discard everything in flight (taken branch/jump).
REQ-010 out_instr  output  INSTR_WIDTH  first word of the assembled instruction.
REQ-011 out_imm  output  INSTR_WIDTH  immediate word; 0 when out_has_imm=0.
REQ-012 out_pc  output  PC_WIDTH  address of the first word of the assembled instruction.
REQ-013 out_has_imm  output  1  the assembled instruction carries an immediate.
REQ-014 out_valid  output  1  outputs hold a complete instruction for decode.
REQ-015 out_count  output  16  number of complete instructions delivered since reset.

Function
REQ-016 The block shall be the IF/ID pipeline register: it registers fetched words and assembles one- or two-word instructions.
REQ-017 A first word with bit [0] = 1 shall be an immediate-bearing instruction; the next valid word is its immediate.
REQ-018 The FSM shall have two states: S_FIRST (expecting an opcode word) and S_IMM (expecting an immediate word).
REQ-019 S_FIRST, in_valid=1, bit[0]=0: next edge loads out_instr=instr_in, out_pc=pc_in, out_imm=0, out_has_imm=0, out_valid=1; stay in S_FIRST.
REQ-020 S_FIRST, in_valid=1, bit[0]=1: capture instr_in and pc_in into internal hold registers, set out_valid=0, go to S_IMM.
REQ-021 S_IMM, in_valid=1: load out_instr=held word, out_pc=held pc, out_imm=instr_in, out_has_imm=1, out_valid=1; go to S_FIRST.
REQ-022 Latency shall be one clock from the edge sampling the last word of an instruction to out_valid=1.
REQ-023 in_valid=0 without stall or flush: out_valid<=0 next edge; state and hold registers are unchanged, so a pending S_IMM waits for its immediate.
REQ-024 stall=1 without flush: state, hold registers, all outputs and out_count are unchanged; the incoming word is dropped, and upstream must re-present it.
REQ-025 flush=1 shall have priority over stall and in_valid: next edge sets out_valid=0, out_has_imm=0, out_instr=0, out_imm=0, state=S_FIRST, hold registers=0; the incoming word is discarded.
REQ-026 out_pc shall keep its last value on flush (debug visibility); it is meaningful only while out_valid=1.
REQ-027 out_count shall increment by 1 on each edge that sets out_valid=1 with a complete instruction, and saturate at 16'hFFFF (no wrap).
REQ-028 An immediate word shall never be interpreted as an opcode; bit [0] is examined only in S_FIRST.

Reset
REQ-029 While rst=1, the block shall set state=S_FIRST, hold registers=0, out_instr=0, out_imm=0, out_pc=0, out_has_imm=0, out_valid=0 and out_count=0, independent of clk.
REQ-030 Reset asserted mid-instruction (in S_IMM) shall abandon the held word; the first valid word after release is treated as an opcode.

Verification
REQ-031 Reset, then words 16'h1234@0x20, 16'h5678@0x21 with in_valid=1 -> cycle+1: out_instr=1234, pc=0x20, valid=1, has_imm=0; cycle+2: out_instr=5678, pc=0x21; out_count=2.
REQ-032 16'h0A01@0x22 then 16'hBEEF@0x23 -> first edge out_valid=0; second edge out_instr=0A01, out_imm=BEEF, out_pc=0x22, out_has_imm=1, out_valid=1.
REQ-033 16'h0A01 accepted, stall=1 for 3 cycles, then 16'hBEEF -> outputs frozen during stall; immediate pairs correctly; out_count increments once.
REQ-034 16'h0A01 accepted, then flush=1 with in_valid=1 and stall=1 -> out_valid=0, state S_FIRST; next word 16'h0002 is delivered as a one-word instruction.
REQ-035 rst pulsed asynchronously while in S_IMM -> all outputs 0 immediately; next word 16'hBEEF is treated as an opcode with bit[0]=1, so state becomes S_IMM.
REQ-036 Force out_count to 16'hFFFE via a long one-word stream -> after two more instructions out_count=16'hFFFF and it stays there.
